// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: write-data select codes and hazard FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Write-data select codes carried with each instruction down the pipe.
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DRAM = 2'b01;  // load: data only exists after MEM
  localparam logic [1:0] WD_PC4  = 2'b10;
  localparam logic [1:0] WD_IMM  = 2'b11;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

  // True when a later stage writes the register an ID operand reads.
  // x0 is hardwired to zero and never takes part in a match.
  function automatic logic reg_hit(
    input logic       re,
    input logic [4:0] rs,
    input logic       we,
    input logic [4:0] wr
  );
    return re && (rs != 5'd0) && we && (wr == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: picks the youngest in-flight producer of one ID source register.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; a load in EX is flagged as load_use instead of being forwarded.
//
// Ports:
//   id_re, id_rs                      operand read enable and index from ID
//   ex_*/mem_*/wb_*                   producer dest, write enable and value per stage
//   ex_wd_sel                         EX write-data select (WD_DRAM marks a load)
//   fwd_op, fwd_dat                   forward enable and value (value is 0 when not forwarding)
//   load_use                          youngest producer is a load still in EX
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic        id_re,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  ex_wR,
  input  logic        ex_rf_we,
  input  logic [1:0]  ex_wd_sel,
  input  logic [31:0] ex_wD,
  input  logic [4:0]  mem_wR,
  input  logic        mem_rf_we,
  input  logic [31:0] mem_wD,
  input  logic [4:0]  wb_wR,
  input  logic        wb_rf_we,
  input  logic [31:0] wb_wD,
  output logic        fwd_op,
  output logic [31:0] fwd_dat,
  output logic        load_use
);

  always_comb begin
    fwd_op   = 1'b0;
    fwd_dat  = 32'd0;
    load_use = 1'b0;
    if (reg_hit(id_re, id_rs, ex_rf_we, ex_wR)) begin
      // The EX load is the youngest writer, so an older MEM/WB value would be
      // stale: forward nothing and let the hazard logic insert a bubble.
      if (ex_wd_sel == WD_DRAM) begin
        load_use = 1'b1;
      end else begin
        fwd_op  = 1'b1;
        fwd_dat = ex_wD;
      end
    end else if (reg_hit(id_re, id_rs, mem_rf_we, mem_wR)) begin
      fwd_op  = 1'b1;
      fwd_dat = mem_wD;
    end else if (reg_hit(id_re, id_rs, wb_rf_we, wb_wR)) begin
      fwd_op  = 1'b1;
      fwd_dat = wb_wD;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: ID operand forwarding, load-use bubbles, EX redirect flushes.
// Latency: 0 cycles, all control/forward outputs are combinational from inputs and FSM state.
// Backpressure: holds PC and IF/ID while injecting ID/EX bubbles; a redirect overrides any stall.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/id_rs2/id_re1/id_re2   ID source indices and read enables
//   ex_*, mem_*, wb_*             producer info per stage; ex_redirect = taken branch/jump in EX
//   pc_stall, if_id_stall         hold PC and IF/ID
//   if_id_flush, id_ex_flush      bubble IF/ID and ID/EX
//   rD1_op/rD1_f, rD2_op/rD2_f    forward enables and values for rs1/rs2
//   perf_stall_cnt/perf_flush_cnt load-use bubble cycles and redirect cycles
// Build option: define HAZARD_PERF_CNT_EN to build the saturating performance counters;
// otherwise both perf outputs are tied to zero.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,  // 1..3 bubbles per load-use hazard
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic [1:0]       ex_wd_sel,
  input  logic [31:0]      ex_wD,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_wR,
  input  logic             mem_rf_we,
  input  logic [31:0]      mem_wD,
  input  logic [4:0]       wb_wR,
  input  logic             wb_rf_we,
  input  logic [31:0]      wb_wD,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             rD1_op,
  output logic             rD2_op,
  output logic [31:0]      rD1_f,
  output logic [31:0]      rD2_f,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  // Bubbles still owed after the one issued in the detecting RUN cycle.
  localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYCLES - 1);

  hz_state_t   state_q, state_nxt;
  logic [1:0]  lu_cnt_q, lu_cnt_nxt;

  logic        fwd1_op, fwd2_op;
  logic [31:0] fwd1_dat, fwd2_dat;
  logic        lu1, lu2, load_use;

  logic        pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c;
  logic        rd1_op_c, rd2_op_c;
  logic [31:0] rd1_f_c, rd2_f_c;
  logic        lu_bubble;  // this cycle's ID/EX flush is a load-use bubble

  fwd_sel u_fwd_rs1 (
    .id_re     (id_re1),
    .id_rs     (id_rs1),
    .ex_wR     (ex_wR),
    .ex_rf_we  (ex_rf_we),
    .ex_wd_sel (ex_wd_sel),
    .ex_wD     (ex_wD),
    .mem_wR    (mem_wR),
    .mem_rf_we (mem_rf_we),
    .mem_wD    (mem_wD),
    .wb_wR     (wb_wR),
    .wb_rf_we  (wb_rf_we),
    .wb_wD     (wb_wD),
    .fwd_op    (fwd1_op),
    .fwd_dat   (fwd1_dat),
    .load_use  (lu1)
  );

  fwd_sel u_fwd_rs2 (
    .id_re     (id_re2),
    .id_rs     (id_rs2),
    .ex_wR     (ex_wR),
    .ex_rf_we  (ex_rf_we),
    .ex_wd_sel (ex_wd_sel),
    .ex_wD     (ex_wD),
    .mem_wR    (mem_wR),
    .mem_rf_we (mem_rf_we),
    .mem_wD    (mem_wD),
    .wb_wR     (wb_wR),
    .wb_rf_we  (wb_rf_we),
    .wb_wD     (wb_wD),
    .fwd_op    (fwd2_op),
    .fwd_dat   (fwd2_dat),
    .load_use  (lu2)
  );

  assign load_use = lu1 | lu2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_nxt;
      lu_cnt_q <= lu_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    lu_cnt_nxt    = lu_cnt_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    lu_bubble     = 1'b0;
    rd1_op_c      = 1'b0;
    rd2_op_c      = 1'b0;
    rd1_f_c       = 32'd0;
    rd2_f_c       = 32'd0;

    // The instruction held in ID during a stall is re-evaluated once back in
    // RUN, when the load result has reached MEM or WB.
    if (state_q == RUN) begin
      rd1_op_c = fwd1_op;
      rd1_f_c  = fwd1_dat;
      rd2_op_c = fwd2_op;
      rd2_f_c  = fwd2_dat;
    end

    if (ex_redirect) begin
      // Instructions in IF/ID are on the wrong path, so holding them is
      // pointless: squash both and let the PC take the new target.
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      state_nxt     = RUN;
      lu_cnt_nxt    = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
            lu_bubble     = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_nxt  = LU_STALL;
              lu_cnt_nxt = LU_INIT;
            end
          end
        end
        LU_STALL: begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          lu_bubble     = 1'b1;
          lu_cnt_nxt    = lu_cnt_q - 2'd1;
          if (lu_cnt_q == 2'd1) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt  = RUN;
          lu_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  // Outputs are held quiet while reset is asserted, independent of the
  // (possibly stale) registered state.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    rD1_op      = 1'b0;
    rD2_op      = 1'b0;
    rD1_f       = 32'd0;
    rD2_f       = 32'd0;
    if (!rst) begin
      pc_stall    = pc_stall_c;
      if_id_stall = if_id_stall_c;
      if_id_flush = if_id_flush_c;
      id_ex_flush = id_ex_flush_c;
      rD1_op      = rd1_op_c;
      rD2_op      = rd2_op_c;
      rD1_f       = rd1_f_c;
      rD2_f       = rd2_f_c;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating: a wrapped counter would read as a near-zero rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ex_redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = rst ? '0 : stall_cnt_q;
  assign perf_flush_cnt = rst ? '0 : flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: three instances (1, 2 and 3 bubbles per load-use) share stimulus.
// Latency: expected outputs are for the same cycle the inputs are applied.
// Backpressure: n/a; a stimulus process pushes expectations, a monitor pops and compares.
module tb_hazard_ctrl;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;

  typedef struct packed {
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        rd1_op;
    logic        rd2_op;
    logic [31:0] rd1_f;
    logic [31:0] rd2_f;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
  logic        id_re1, id_re2, ex_rf_we, mem_rf_we, wb_rf_we, ex_redirect;
  logic [1:0]  ex_wd_sel;
  logic [31:0] ex_wD, mem_wD, wb_wD;

  logic        o_pcs [3];
  logic        o_ifs [3];
  logic        o_iff [3];
  logic        o_idf [3];
  logic        o_op1 [3];
  logic        o_op2 [3];
  logic [31:0] o_f1  [3];
  logic [31:0] o_f2  [3];
  logic [31:0] o_sc  [3];
  logic [31:0] o_fc  [3];

  exp_t q0[$], q1[$], q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: bubbles still owed and event counts, per instance.
  int     owed [3];
  longint scnt [3];
  longint fcnt [3];

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel), .ex_wD(ex_wD),
    .ex_redirect(ex_redirect), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_wD(mem_wD),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .wb_wD(wb_wD),
    .pc_stall(o_pcs[0]), .if_id_stall(o_ifs[0]), .if_id_flush(o_iff[0]), .id_ex_flush(o_idf[0]),
    .rD1_op(o_op1[0]), .rD2_op(o_op2[0]), .rD1_f(o_f1[0]), .rD2_f(o_f2[0]),
    .perf_stall_cnt(o_sc[0]), .perf_flush_cnt(o_fc[0]));

  hazard_ctrl #(.LU_STALL_CYCLES(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel), .ex_wD(ex_wD),
    .ex_redirect(ex_redirect), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_wD(mem_wD),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .wb_wD(wb_wD),
    .pc_stall(o_pcs[1]), .if_id_stall(o_ifs[1]), .if_id_flush(o_iff[1]), .id_ex_flush(o_idf[1]),
    .rD1_op(o_op1[1]), .rD2_op(o_op2[1]), .rD1_f(o_f1[1]), .rD2_f(o_f2[1]),
    .perf_stall_cnt(o_sc[1]), .perf_flush_cnt(o_fc[1]));

  hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel), .ex_wD(ex_wD),
    .ex_redirect(ex_redirect), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_wD(mem_wD),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .wb_wD(wb_wD),
    .pc_stall(o_pcs[2]), .if_id_stall(o_ifs[2]), .if_id_flush(o_iff[2]), .id_ex_flush(o_idf[2]),
    .rD1_op(o_op1[2]), .rD2_op(o_op2[2]), .rD1_f(o_f1[2]), .rD2_f(o_f2[2]),
    .perf_stall_cnt(o_sc[2]), .perf_flush_cnt(o_fc[2]));

  function automatic exp_t actual(input int k);
    exp_t a;
    a.pc_stall    = o_pcs[k];
    a.if_id_stall = o_ifs[k];
    a.if_id_flush = o_iff[k];
    a.id_ex_flush = o_idf[k];
    a.rd1_op      = o_op1[k];
    a.rd2_op      = o_op2[k];
    a.rd1_f       = o_f1[k];
    a.rd2_f       = o_f2[k];
    a.stall_cnt   = o_sc[k];
    a.flush_cnt   = o_fc[k];
    return a;
  endfunction

  // Operand value as seen from ID: scan producers youngest-first; the first
  // one writing the register decides. A load still in EX has no value yet.
  task automatic ref_operand(input logic re, input logic [4:0] rs,
                             output logic op, output logic [31:0] val, output logic is_lu);
    logic        we [3];
    logic [4:0]  wr [3];
    logic [31:0] wd [3];
    we = '{ex_rf_we, mem_rf_we, wb_rf_we};
    wr = '{ex_wR, mem_wR, wb_wR};
    wd = '{ex_wD, mem_wD, wb_wD};
    op = 1'b0; val = 32'd0; is_lu = 1'b0;
    if (re && rs != 5'd0) begin
      for (int s = 0; s < 3; s++) begin
        if (we[s] && wr[s] == rs) begin
          if (s == 0 && ex_wd_sel == SEL_LOAD) is_lu = 1'b1;
          else begin op = 1'b1; val = wd[s]; end
          break;
        end
      end
    end
  endtask

  // Compute and queue this cycle's expectation for all three instances,
  // advance the reference, then move to just after the next rising edge.
  task automatic step();
    exp_t        e;
    logic        op1, op2, lu1, lu2, stalled, lu;
    logic [31:0] v1, v2;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      stalled = (owed[k] > 0);
      ref_operand(id_re1, id_rs1, op1, v1, lu1);
      ref_operand(id_re2, id_rs2, op2, v2, lu2);
      lu = !stalled && (lu1 || lu2);
      if (!rst) begin
        if (!stalled) begin
          e.rd1_op = op1; e.rd1_f = v1;
          e.rd2_op = op2; e.rd2_f = v2;
        end
        if (ex_redirect) begin
          e.if_id_flush = 1'b1;
          e.id_ex_flush = 1'b1;
        end else if (stalled || lu) begin
          e.pc_stall    = 1'b1;
          e.if_id_stall = 1'b1;
          e.id_ex_flush = 1'b1;
        end
`ifdef HAZARD_PERF_CNT_EN
        e.stall_cnt = scnt[k][31:0];
        e.flush_cnt = fcnt[k][31:0];
`endif
      end
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);

      if (rst) begin
        owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else if (ex_redirect) begin
        owed[k] = 0;
        if (fcnt[k] < 64'hFFFF_FFFF) fcnt[k]++;
      end else if (stalled) begin
        owed[k]--;
        if (scnt[k] < 64'hFFFF_FFFF) scnt[k]++;
      end else if (lu) begin
        owed[k] = k;  // instance k inserts k+1 bubbles in total
        if (scnt[k] < 64'hFFFF_FFFF) scnt[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_wR = 5'd0; ex_rf_we = 1'b0; ex_wd_sel = SEL_ALU; ex_wD = 32'd0; ex_redirect = 1'b0;
    mem_wR = 5'd0; mem_rf_we = 1'b0; mem_wD = 32'd0;
    wb_wR = 5'd0; wb_rf_we = 1'b0; wb_wD = 32'd0;
  endtask

  task automatic check(input string name, input exp_t exp_v, input exp_t act_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act_v, exp_v);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) check("lu1", q0.pop_front(), actual(0));
    if (q1.size() > 0) check("lu2", q1.pop_front(), actual(1));
    if (q2.size() > 0) check("lu3", q2.pop_front(), actual(2));
  end

  initial begin
    for (int k = 0; k < 3; k++) begin owed[k] = 0; scnt[k] = 0; fcnt[k] = 0; end
    clear_inputs();
    @(posedge clk);
    #1;
    // Reset with hazard-looking inputs: outputs must still be quiet.
    rst = 1'b1; id_re1 = 1'b1; id_rs1 = 5'd4; ex_wR = 5'd4; ex_rf_we = 1'b1; ex_redirect = 1'b1;
    step(); step();
    clear_inputs();
    step();

    // EX ALU result forwarded to rs1.
    ex_wR = 5'd5; ex_rf_we = 1'b1; ex_wD = 32'h11; id_rs1 = 5'd5; id_re1 = 1'b1;
    step();
    // Priority EX > MEM > WB on rs2.
    clear_inputs();
    id_rs2 = 5'd7; id_re2 = 1'b1;
    ex_wR = 5'd7;  ex_rf_we = 1'b1;  ex_wD = 32'hA;
    mem_wR = 5'd7; mem_rf_we = 1'b1; mem_wD = 32'hB;
    wb_wR = 5'd7;  wb_rf_we = 1'b1;  wb_wD = 32'hC;
    step();
    ex_rf_we = 1'b0;  step();
    mem_rf_we = 1'b0; step();
    // x0 never forwarded.
    clear_inputs();
    id_rs1 = 5'd0; id_re1 = 1'b1; ex_wR = 5'd0; ex_rf_we = 1'b1; ex_wD = 32'h99;
    step();
    // Load-use then resolution via MEM, then WB.
    clear_inputs();
    ex_wR = 5'd3; ex_rf_we = 1'b1; ex_wd_sel = SEL_LOAD; ex_wD = 32'hDEAD; id_rs2 = 5'd3; id_re2 = 1'b1;
    step();
    ex_rf_we = 1'b0; mem_wR = 5'd3; mem_rf_we = 1'b1; mem_wD = 32'h55;
    step();
    mem_rf_we = 1'b0; wb_wR = 5'd3; wb_rf_we = 1'b1; wb_wD = 32'h55;
    step(); step();
    // Load-use together with redirect: redirect wins.
    clear_inputs();
    ex_wR = 5'd9; ex_rf_we = 1'b1; ex_wd_sel = SEL_LOAD; id_rs1 = 5'd9; id_re1 = 1'b1; ex_redirect = 1'b1;
    step();
    // Load-use, then redirect aborts the longer stalls.
    ex_redirect = 1'b0; step();
    clear_inputs(); ex_redirect = 1'b1; step();
    ex_redirect = 1'b0; step(); step();
    // Reset while stalled.
    ex_wR = 5'd2; ex_rf_we = 1'b1; ex_wd_sel = SEL_LOAD; id_rs1 = 5'd2; id_re1 = 1'b1;
    step();
    clear_inputs(); rst = 1'b1; step();
    rst = 1'b0; step(); step();

    // Random traffic over a small register window so hazards are common.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 127) == 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_re1      = ($urandom_range(0, 3) != 0);
      id_re2      = ($urandom_range(0, 3) != 0);
      ex_wR       = 5'($urandom_range(0, 7));
      ex_rf_we    = ($urandom_range(0, 3) != 0);
      ex_wd_sel   = 2'($urandom_range(0, 3));
      ex_wD       = $urandom;
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_wR      = 5'($urandom_range(0, 7));
      mem_rf_we   = ($urandom_range(0, 3) != 0);
      mem_wD      = $urandom;
      wb_wR       = 5'($urandom_range(0, 7));
      wb_rf_we    = ($urandom_range(0, 3) != 0);
      wb_wD       = $urandom;
      step();
    end

    clear_inputs();
    for (int i = 0; i < 10 && (q0.size() + q1.size() + q2.size()) > 0; i++) @(posedge clk);
    n_checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q0.size() + q1.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
